// File: rtl/mem_dep_counter_predictor_pkg.sv
// Shared scheduler types for the memory-dependence counter predictor:
// counter/index types, FSM state encoding and the PC-to-index hash.
package mem_dep_counter_predictor_pkg;

  localparam int unsigned MDCP_DEF_ENTRY_NUM = 1024;
  localparam int unsigned MDCP_DEF_CNT_BITS  = 2;
  localparam int unsigned MDCP_DEF_IDX_BITS  = $clog2(MDCP_DEF_ENTRY_NUM);

  typedef logic [MDCP_DEF_CNT_BITS-1:0] mdcp_cnt_t;
  typedef logic [MDCP_DEF_IDX_BITS-1:0] mdcp_idx_t;

  typedef enum logic [1:0] {
    MDCP_INIT  = 2'd0,
    MDCP_RUN   = 2'd1,
    MDCP_DECAY = 2'd2
  } mdcp_state_e;

  // Drop the instruction-alignment bits, keep idx_bits above them; upper bits alias.
  function automatic logic [63:0] ToMdcpIndex(input logic [63:0] pc,
                                              input int unsigned off_bits,
                                              input int unsigned idx_bits);
    logic [63:0] mask;
    mask = (64'd1 << idx_bits) - 64'd1;
    return (pc >> off_bits) & mask;
  endfunction

endpackage

// File: rtl/mem_dep_counter_predictor_counter_table.sv
// Saturating-counter storage: registered read ports, one merged write per entry
// per cycle where a training increment overrides the sweep clear/decrement.
module mdcp_counter_table
  import mem_dep_counter_predictor_pkg::*;
#(
  parameter int unsigned ENTRY_NUM = MDCP_DEF_ENTRY_NUM,
  parameter int unsigned CNT_BITS  = MDCP_DEF_CNT_BITS,
  parameter int unsigned READ_NUM  = 2,
  parameter int unsigned WRITE_NUM = 2,
  parameter int unsigned IDX_W     = $clog2(ENTRY_NUM)
) (
  input  logic                                 clk,
  input  logic [READ_NUM-1:0][IDX_W-1:0]       rd_idx_i,
  output logic [READ_NUM-1:0][CNT_BITS-1:0]    rd_cnt_o,
  input  logic [WRITE_NUM-1:0]                 inc_en_i,
  input  logic [WRITE_NUM-1:0][IDX_W-1:0]      inc_idx_i,
  input  logic                                 sweep_en_i,
  input  logic                                 sweep_clr_i,
  input  logic [IDX_W-1:0]                     sweep_idx_i
);

  logic [CNT_BITS-1:0] cnt_q [ENTRY_NUM];

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (v == {CNT_BITS{1'b1}}) ? v : v + CNT_BITS'(1);
  endfunction

  function automatic logic [CNT_BITS-1:0] sat_dec(input logic [CNT_BITS-1:0] v);
    return (v == {CNT_BITS{1'b0}}) ? v : v - CNT_BITS'(1);
  endfunction

  // Reads see pre-write contents; later increments replace the sweep write so
  // training wins, and duplicate ports on one index write the same value.
  always_ff @(posedge clk) begin
    for (int r = 0; r < int'(READ_NUM); r++) begin
      rd_cnt_o[r] <= cnt_q[rd_idx_i[r]];
    end
    if (sweep_en_i) begin
      cnt_q[sweep_idx_i] <= sweep_clr_i ? {CNT_BITS{1'b0}} : sat_dec(cnt_q[sweep_idx_i]);
    end
    for (int w = 0; w < int'(WRITE_NUM); w++) begin
      if (inc_en_i[w]) begin
        cnt_q[inc_idx_i[w]] <= sat_inc(cnt_q[inc_idx_i[w]]);
      end
    end
  end

endmodule

// File: rtl/mem_dep_counter_predictor.sv
// Memory-dependence predictor: PC-indexed saturating counters trained by
// order violations, with an init sweep and periodic decay sweeps.
module mem_dep_counter_predictor
  import mem_dep_counter_predictor_pkg::*;
#(
  parameter int unsigned ENTRY_NUM       = MDCP_DEF_ENTRY_NUM,
  parameter int unsigned READ_NUM        = 2,
  parameter int unsigned WRITE_NUM       = 2,
  parameter int unsigned CNT_BITS        = MDCP_DEF_CNT_BITS,
  parameter int unsigned THRESHOLD       = 2,
  parameter int unsigned DECAY_PERIOD    = 65536,
  parameter int unsigned PC_WIDTH        = 32,
  parameter int unsigned INSN_BYTE_WIDTH = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic [PC_WIDTH-1:0]                 lookupPC,
  input  logic [READ_NUM-1:0]                 lookupValid,
  output logic [READ_NUM-1:0]                 pred,
  input  logic [WRITE_NUM-1:0]                violation,
  input  logic [WRITE_NUM-1:0][PC_WIDTH-1:0]  violationPC,
  output logic                                ready
);

  localparam int unsigned IDX_W = $clog2(ENTRY_NUM);
  localparam int unsigned OFF_W = $clog2(INSN_BYTE_WIDTH);
  localparam int unsigned TMR_W = $clog2(DECAY_PERIOD);

  mdcp_state_e                          state_q;
  logic [IDX_W-1:0]                     ptr_q;
  logic [TMR_W-1:0]                     timer_q;
  logic [READ_NUM-1:0]                  valid_q;
  logic [READ_NUM-1:0][IDX_W-1:0]       rd_idx;
  logic [READ_NUM-1:0][CNT_BITS-1:0]    rd_cnt;
  logic [WRITE_NUM-1:0][IDX_W-1:0]      inc_idx;
  logic [WRITE_NUM-1:0]                 inc_en;
  logic                                 sweep_en;
  logic                                 sweep_clr;

  for (genvar g = 0; g < int'(READ_NUM); g++) begin : g_rd
    assign rd_idx[g] = IDX_W'(ToMdcpIndex(64'(lookupPC + PC_WIDTH'(g * INSN_BYTE_WIDTH)),
                                          OFF_W, IDX_W));
  end

  for (genvar g = 0; g < int'(WRITE_NUM); g++) begin : g_wr
    assign inc_idx[g] = IDX_W'(ToMdcpIndex(64'(violationPC[g]), OFF_W, IDX_W));
  end

  // Training is dropped while the table is being initialised; a flush cancels the sweep write.
  always_comb begin
    inc_en    = (state_q != MDCP_INIT) ? violation : {WRITE_NUM{1'b0}};
    sweep_en  = !flush && (state_q != MDCP_RUN);
    sweep_clr = (state_q == MDCP_INIT);
  end

  mdcp_counter_table #(
    .ENTRY_NUM (ENTRY_NUM),
    .CNT_BITS  (CNT_BITS),
    .READ_NUM  (READ_NUM),
    .WRITE_NUM (WRITE_NUM),
    .IDX_W     (IDX_W)
  ) u_table (
    .clk         (clk),
    .rd_idx_i    (rd_idx),
    .rd_cnt_o    (rd_cnt),
    .inc_en_i    (inc_en),
    .inc_idx_i   (inc_idx),
    .sweep_en_i  (sweep_en),
    .sweep_clr_i (sweep_clr),
    .sweep_idx_i (ptr_q)
  );

  // Sweep/decay FSM; lookups issued during INIT never produce a real prediction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MDCP_INIT;
      ptr_q   <= '0;
      timer_q <= '0;
      valid_q <= '0;
    end else begin
      valid_q <= (state_q != MDCP_INIT) ? lookupValid : {READ_NUM{1'b0}};
      if (flush) begin
        state_q <= MDCP_INIT;
        ptr_q   <= '0;
        timer_q <= '0;
      end else begin
        case (state_q)
          MDCP_INIT: begin
            if (ptr_q == IDX_W'(ENTRY_NUM - 1)) begin
              state_q <= MDCP_RUN;
              ptr_q   <= '0;
            end else begin
              ptr_q <= ptr_q + IDX_W'(1);
            end
          end
          MDCP_RUN: begin
            if (timer_q == TMR_W'(DECAY_PERIOD - 1)) begin
              state_q <= MDCP_DECAY;
              ptr_q   <= '0;
              timer_q <= '0;
            end else begin
              timer_q <= timer_q + TMR_W'(1);
            end
          end
          MDCP_DECAY: begin
            if (ptr_q == IDX_W'(ENTRY_NUM - 1)) begin
              state_q <= MDCP_RUN;
              ptr_q   <= '0;
            end else begin
              ptr_q <= ptr_q + IDX_W'(1);
            end
          end
          default: begin
            state_q <= MDCP_INIT;
            ptr_q   <= '0;
            timer_q <= '0;
          end
        endcase
      end
    end
  end

  // Outputs decode directly from registered state and registered table reads.
  always_comb begin
    pred  = {READ_NUM{1'b1}};
    ready = (state_q != MDCP_INIT);
    if (state_q != MDCP_INIT) begin
      for (int i = 0; i < int'(READ_NUM); i++) begin
        pred[i] = valid_q[i] && (rd_cnt[i] >= CNT_BITS'(THRESHOLD));
      end
    end else begin
      pred = {READ_NUM{1'b1}};
    end
  end

endmodule

// File: tb/tb_mem_dep_counter_predictor.sv
// Scoreboard bench: a cycle model predicts pred/ready for each driven cycle,
// the expectation is queued and compared once the DUT produces the output.
module tb_mem_dep_counter_predictor;

  localparam int EN = 16;
  localparam int DP = 32;
  localparam int TH = 2;
  localparam int CMAX = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [31:0]      lookupPC;
  logic [1:0]       lookupValid;
  logic [1:0]       pred;
  logic [1:0]       violation;
  logic [1:0][31:0] violationPC;
  logic             ready;

  always #5 clk = ~clk;

  mem_dep_counter_predictor #(
    .ENTRY_NUM(EN), .READ_NUM(2), .WRITE_NUM(2), .CNT_BITS(2), .THRESHOLD(TH),
    .DECAY_PERIOD(DP), .PC_WIDTH(32), .INSN_BYTE_WIDTH(4)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .lookupPC(lookupPC),
    .lookupValid(lookupValid), .pred(pred), .violation(violation),
    .violationPC(violationPC), .ready(ready)
  );

  typedef struct packed { logic [1:0] pred; logic ready; } exp_t;
  exp_t sb_q[$];

  int n_vec = 0;
  int n_err = 0;
  int ms, mp, mt;     // model state (0 INIT, 1 RUN, 2 DECAY), pointer, timer
  int mc[EN];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) & 32'd15);
  endfunction

  // One clock: drive at negedge, queue expectation, advance model, compare at next negedge.
  task automatic step(input logic [1:0] lv, input logic [31:0] lpc, input logic [1:0] vi,
                      input logic [31:0] v0, input logic [31:0] v1, input logic fl);
    exp_t e;
    exp_t got;
    int   ns;
    int   nc[EN];
    int   k;
    lookupValid = lv; lookupPC = lpc; violation = vi;
    violationPC[0] = v0; violationPC[1] = v1; flush = fl;
    if (fl) ns = 0;
    else if (ms == 0) ns = (mp == EN - 1) ? 1 : 0;
    else if (ms == 1) ns = (mt == DP - 1) ? 2 : 1;
    else ns = (mp == EN - 1) ? 1 : 2;
    e.ready = (ns != 0);
    if (ns == 0) e.pred = 2'b11;
    else if (ms == 0) e.pred = 2'b00;
    else for (int i = 0; i < 2; i++)
      e.pred[i] = lv[i] && (mc[idx_of(lpc + 32'(4 * i))] >= TH);
    sb_q.push_back(e);
    @(posedge clk);
    nc = mc;
    if (ms == 0) begin
      if (!fl) nc[mp] = 0;
    end else begin
      if (ms == 2 && !fl && mc[mp] > 0) nc[mp] = mc[mp] - 1;
      for (int p = 0; p < 2; p++) begin
        if (vi[p]) begin
          k = idx_of(p == 0 ? v0 : v1);
          nc[k] = (mc[k] == CMAX) ? CMAX : mc[k] + 1;
        end
      end
    end
    mc = nc;
    if (fl) begin mp = 0; mt = 0; end
    else if (ms == 0) mp = (mp == EN - 1) ? 0 : mp + 1;
    else if (ms == 1) begin
      if (mt == DP - 1) begin mt = 0; mp = 0; end else mt = mt + 1;
    end else mp = (mp == EN - 1) ? 0 : mp + 1;
    ms = ns;
    @(negedge clk);
    got = sb_q.pop_front();
    check("pred", {30'd0, pred}, {30'd0, got.pred});
    check("ready", {31'd0, ready}, {31'd0, got.ready});
  endtask

  task automatic idle(input logic [31:0] lpc);
    step(2'b11, lpc, 2'b00, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic train(input logic [1:0] vi, input logic [31:0] v0, input logic [31:0] v1);
    step(2'b00, 32'h0, vi, v0, v1, 1'b0);
  endtask

  // Idle until the model reaches the given state/pointer, bounded.
  task automatic wait_model(input int st, input int ptr, input logic [31:0] lpc, input string tag);
    bit ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (ms == st && mp == ptr) begin ok = 1'b1; break; end
      idle(lpc);
    end
    check(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    #1;
    check("rst_pred", {30'd0, pred}, 32'h3);
    check("rst_ready", {31'd0, ready}, 32'd0);
    ms = 0; mp = 0; mt = 0;
    sb_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  // Counts cycles with ready low from reset release / flush edge until ready rises.
  task automatic count_init(input int start, input string tag);
    int k = start;
    for (int n = 0; n < 100; n++) begin
      idle(32'h100);
      if (ready) break;
      k++;
    end
    check(tag, 32'(k), 32'(EN));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; lookupPC = '0; lookupValid = '0;
    violation = '0; violationPC = '0;
    for (int i = 0; i < EN; i++) mc[i] = 0;
    #2;
    apply_reset();
    count_init(1, "init_len_reset");
    repeat (2) idle(32'h100);

    // single-port training on 0x100: below threshold after one, predicted after two
    train(2'b01, 32'h100, 32'h0);
    idle(32'h100);
    train(2'b01, 32'h100, 32'h0);
    idle(32'h100);

    // both ports on one index in one cycle count once
    train(2'b11, 32'h104, 32'h104);
    idle(32'h104);
    idle(32'h100);

    // saturate idx 2, then watch two decay sweeps; idx 3 stays at 0
    repeat (4) train(2'b01, 32'h108, 32'h0);
    for (int n = 0; n < 2 * (DP + EN) + 8; n++) idle(32'h108);

    // violation meets the decay of the same entry
    wait_model(1, 0, 32'h110, "wait_run");
    train(2'b10, 32'h0, 32'h110);
    wait_model(2, 4, 32'h110, "wait_decay4");
    train(2'b01, 32'h110, 32'h0);
    idle(32'h110);

    // random traffic including occasional flushes
    for (int n = 0; n < 250; n++) begin
      step(2'(($urandom_range(0, 3))), 32'h100 + 32'(4 * $urandom_range(0, 20)),
           ($urandom_range(0, 3) == 0) ? 2'(($urandom_range(1, 3))) : 2'b00,
           32'h100 + 32'(4 * $urandom_range(0, 7)), 32'h100 + 32'(4 * $urandom_range(0, 7)),
           ($urandom_range(0, 63) == 0));
    end

    // flush mid-decay at pointer 7, then every entry must read 0
    wait_model(2, 7, 32'h100, "wait_decay7");
    step(2'b11, 32'h100, 2'b00, 32'h0, 32'h0, 1'b1);
    count_init(1, "init_len_flush");
    for (int e = 0; e < EN; e += 2) idle(32'h100 + 32'(4 * e));

    // asynchronous reset in the middle of a decay sweep
    train(2'b01, 32'h100, 32'h0);
    wait_model(2, 5, 32'h100, "wait_decay5");
    apply_reset();
    count_init(1, "init_len_rst2");
    idle(32'h100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_dep_counter_predictor.md
MEM_DEP_COUNTER_PREDICTOR -- requirements
Module: mem_dep_counter_predictor

Interface
REQ-001 Parameters SHALL be (name, default, meaning): ENTRY_NUM, 1024, table entries, power of two >= 4.
REQ-002 READ_NUM, 2, lookup ports (rename width); WRITE_NUM, 2, violation-train ports.
REQ-003 CNT_BITS, 2, counter width; THRESHOLD, 2, counter value at or above which a load is predicted dependent.
REQ-004 DECAY_PERIOD, 65536, cycles between decay sweeps; PC_WIDTH, 32; INSN_BYTE_WIDTH, 4.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst  in  1  reset; asynchronous and active-low.
REQ-007 flush  in  1  one-cycle pulse that restarts table initialisation.
REQ-008 lookupPC  in  PC_WIDTH  PC of slot 0; slot i uses lookupPC + i*INSN_BYTE_WIDTH.
REQ-009 lookupValid  in  READ_NUM  per-slot lookup request.
REQ-010 pred  out  READ_NUM  1 = issue load non-speculatively.
REQ-011 violation  in  WRITE_NUM  per-port memory-order-violation train request.
REQ-012 violationPC  in  WRITE_NUM x PC_WIDTH  PC of the violating load.
REQ-013 ready  out  1  table initialised; low during INIT.

Function
REQ-014 Index SHALL be PC[INSN_BYTE_WIDTH-aligned bits log2(ENTRY_NUM)+log2(INSN_BYTE_WIDTH)-1 : log2(INSN_BYTE_WIDTH)]; upper bits are ignored (aliasing permitted).
REQ-015 Lookup latency SHALL be 1 cycle: pred[i] in cycle t+1 = (counter[idx_i] at t >= THRESHOLD); pred[i] = 0 when lookupValid[i] was 0.
REQ-016 FSM states SHALL be INIT, RUN, DECAY; reset and flush enter INIT with sweep pointer 0.
REQ-017 INIT: one entry cleared per cycle, pointer 0..ENTRY_NUM-1; after the last entry go to RUN; ready=0, pred forced all-1, violations dropped.
REQ-018 RUN: decay timer counts up; when it reaches DECAY_PERIOD-1, go to DECAY with pointer 0 and timer cleared.
REQ-019 DECAY: one entry per cycle decremented by 1 (saturating at 0); after entry ENTRY_NUM-1 return to RUN; lookups and training stay active, ready=1.
REQ-020 Training: each valid violation port SHALL set its counter to saturate(old+1) clamped at 2^CNT_BITS-1.
REQ-021 Several ports hitting one index in one cycle SHALL increment that entry once.
REQ-022 Violation and decay on the same entry in one cycle: violation wins, result saturate(old+1), no decrement.
REQ-023 Lookup and write to the same entry in one cycle: lookup returns the pre-write value.
REQ-024 flush in any state SHALL abort the current sweep and re-enter INIT the next cycle; flush during INIT restarts at pointer 0.
REQ-025 Pointer and timer SHALL wrap to 0 without overflow into adjacent state.

Reset
REQ-026 On rst low: state=INIT, pointer=0, timer=0, pred=all-1, ready=0; table contents are not reset (cleared by INIT sweep).
REQ-027 rst low mid-DECAY or mid-INIT SHALL take effect immediately; the sweep restarts after release.

Structure
REQ-028 Counter type, index type, FSM state enum and ToMdcpIndex function SHALL live in the shared scheduler types package.
REQ-029 Table SHALL be a separate sub-module mdcp_counter_table (READ_NUM read ports registered, one merged write per entry per cycle, no reset).

Verification
REQ-030 Reset release, ENTRY_NUM=16 -> ready=0 for exactly 16 cycles, then 1; pred all-1 throughout INIT, then all-0 for any lookup.
REQ-031 violation[0] PC 0x100 twice, lookup 0x100 -> pred[0]=1 after second train (counter 2, THRESHOLD 2); after one train, pred=0.
REQ-032 Both ports PC 0x100 same cycle from counter 0 -> counter 1, pred=0.
REQ-033 Counter 3, DECAY_PERIOD=32 -> after one sweep counter 2, pred=1; after two sweeps pred=0; counter 0 stays 0.
REQ-034 Violation on entry being decayed same cycle, counter 1 -> counter 2.
REQ-035 flush mid-DECAY at pointer 7 -> INIT from 0, ready=0 for ENTRY_NUM cycles, all counters 0 afterwards.
